// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: folds a burst of operands into carry-save form,
// then resolves the redundant pair with a segmented carry-propagate adder.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACC     | accepting operands, compressing into (s, c)
// RESOLVE | adding one CHUNK-wide slice of s + c per cycle into result
// DONE    | result presented on out_sum/out_count until out_ready
module csa_accumulator #(
    parameter int W     = 43,
    parameter int CHUNK = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [CNT_W-1:0] out_count
);

    localparam int NSEG  = (W + CHUNK - 1) / CHUNK;
    localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST   = SEG_W'(NSEG - 1);
    localparam logic [W-1:0]     CHUNK_MASK = ~({W{1'b1}} << CHUNK);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ACC,
        RESOLVE,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     s;
    logic [W-1:0]     c;
    logic [W-1:0]     result;
    logic [CNT_W-1:0] cnt;
    logic [SEG_W-1:0] seg;
    logic             carry;

    logic [W-1:0]     s_next;
    logic [W-2:0]     maj_lo;
    logic [W-1:0]     c_next;
    logic [31:0]      shamt;
    logic [CHUNK-1:0] s_slice;
    logic [CHUNK-1:0] c_slice;
    logic [CHUNK:0]   seg_sum;
    logic [W-1:0]     result_next;
    logic [CNT_W-1:0] cnt_next;

    // 3:2 compressor row; the top majority bit would land at weight 2^W and is dropped.
    assign s_next = s ^ c ^ in_data;
    assign maj_lo = (s[W-2:0] & c[W-2:0]) | (s[W-2:0] & in_data[W-2:0])
                  | (c[W-2:0] & in_data[W-2:0]);
    assign c_next = {maj_lo, 1'b0};

    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Bits shifted past W read as zero, so the short top segment needs no special case.
    assign shamt       = 32'(seg) * CHUNK;
    assign s_slice     = CHUNK'(s >> shamt);
    assign c_slice     = CHUNK'(c >> shamt);
    assign seg_sum     = {1'b0, s_slice} + {1'b0, c_slice} + (CHUNK + 1)'(carry);
    assign result_next = (result & ~(CHUNK_MASK << shamt))
                       | (W'(seg_sum[CHUNK-1:0]) << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            s         <= '0;
            c         <= '0;
            result    <= '0;
            cnt       <= '0;
            seg       <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        s   <= s_next;
                        c   <= c_next;
                        cnt <= cnt_next;
                        if (in_last) begin
                            state    <= RESOLVE;
                            seg      <= '0;
                            carry    <= 1'b0;
                            in_ready <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    result <= result_next;
                    carry  <= seg_sum[CHUNK];
                    if (seg == SEG_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_sum   <= result_next;
                        out_count <= cnt;
                    end else begin
                        seg <= seg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACC;
                        s         <= '0;
                        c         <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_count <= '0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: a W=43/CHUNK=11 instance plus a W=16/CHUNK=16/CNT_W=2 instance.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [42:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [42:0] out_sum;
    logic [15:0] out_count;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_in_data = '0;
    logic        s_in_last = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_out_sum;
    logic [1:0]  s_out_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_accumulator #(.W(43), .CHUNK(11), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
    );

    csa_accumulator #(.W(16), .CHUNK(16), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
        .out_count(s_out_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic [42:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [42:0] esum,
                                 input logic [15:0] ecnt, input int elat, input int stall);
        int lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (elat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_sum"}, 64'(out_sum), 64'(esum));
        chk({tag, "_count"}, 64'(out_count), 64'(ecnt));
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_after_take"}, {61'd0, out_valid, in_ready, |out_sum}, 64'b010);
    endtask

    initial begin
        logic [42:0] model;
        int          n;
        int          lat;
        int          seen_valid;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {out_valid, in_ready, out_sum, out_count}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_first_edge", 64'(in_ready), 64'd1);

        // Single operand, burst of one
        send(43'h123456789AB, 1'b1);
        expect_result("single", 43'h123456789AB, 16'd1, 4, 0);

        // Carry ripple across all four segments
        send(43'h7FFFFFFFFFF, 1'b0);
        send(43'h7FFFFFFFFFF, 1'b0);
        send(43'h7FFFFFFFFFF, 1'b1);
        expect_result("ripple", 43'h7FFFFFFFFFD, 16'd3, 4, 0);

        // Output stall with an operand held at the input that must not be consumed
        send(43'd5, 1'b0);
        send(43'd7, 1'b0);
        send(43'd9, 1'b1);
        in_valid = 1'b1;
        in_data  = 43'h100;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_sum", 64'(out_sum), 64'h15);
            chk("stall_ready_valid", {62'd0, in_ready, out_valid}, 64'b01);
            @(negedge clk);
        end
        in_valid = 1'b0;
        expect_result("stall_take", 43'h15, 16'd3, -1, 0);
        send(43'd1, 1'b1);
        expect_result("after_stall", 43'd1, 16'd1, 4, 0);

        // Input gaps leave the accumulation untouched
        send(43'h3, 1'b0);
        repeat (3) @(negedge clk);
        send(43'h40000000000, 1'b0);
        @(negedge clk);
        send(43'h40000000001, 1'b1);
        expect_result("gaps", 43'h4, 16'd3, 4, 2);

        // Reset during RESOLVE discards the burst
        send(43'h777, 1'b0);
        send(43'h888, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_resolve_rst", {out_valid, in_ready, out_sum, out_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("no_valid_after_rst", 64'(seen_valid), 64'd0);
        send(43'h10, 1'b0);
        send(43'h20, 1'b1);
        expect_result("post_rst", 43'h30, 16'd2, 4, 0);

        // Random bursts against a modular sum
        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(1, 20);
            model = '0;
            for (int i = 0; i < n; i++) begin
                logic [42:0] d;
                d = 43'({$urandom, $urandom});
                model = model + d;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(d, i == n - 1);
            end
            expect_result("rand", model, 16'(n), 4, $urandom_range(0, 3));
        end

        // Single-segment instance with counter saturation
        for (int i = 0; i < 5; i++) begin
            int t = 0;
            s_in_valid = 1'b1;
            s_in_data  = 16'hFFFF;
            s_in_last  = (i == 4);
            while (!s_in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!s_in_ready) chk("small_ready_timeout", 64'(s_in_ready), 64'd1);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("small_latency", 64'(lat), 64'd1);
        chk("small_sum", 64'(s_out_sum), 64'hFFFB);
        chk("small_count_sat", 64'(s_out_count), 64'd3);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("small_after_take", {62'd0, s_out_valid, s_in_ready}, 64'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
